// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the md_op encodings used by the controller and the unit, the
// sequencer state type and the default busy durations.
package mdu_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Operations that occupy the unit for a multi-cycle busy period.
   function automatic logic is_long_op(md_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div_op(md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the MIPS controller/datapath and the
// multiply/divide unit.
//   start, md_op    : one-cycle request and its operation code
//   rs_val, rt_val  : operands from the register file read ports
//   busy            : long operation in progress
//   hi, lo          : HI/LO registers for mfhi/mflo write-back
interface mult_div_unit_if;
   import mdu_pkg::*;

   logic          start;
   md_op_t        md_op;
   logic [31:0]   rs_val;
   logic [31:0]   rt_val;
   logic          busy;
   logic [31:0]   hi;
   logic [31:0]   lo;

   modport master (
      output start, md_op, rs_val, rt_val,
      input  busy, hi, lo
   );

   modport slave (
      input  start, md_op, rs_val, rt_val,
      output busy, hi, lo
   );

endinterface

// File: rtl/mdu_arith.sv
// Combinational arithmetic core of the multiply/divide unit.
//   md_op       : operation (only MULT/MULTU/DIV/DIVU produce results)
//   a, b        : operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   res_hi/lo   : HI/LO result for the operation
//   div_by_zero : divide operation with a zero divisor
module mdu_arith
   import mdu_pkg::*;
(
   input  md_op_t        md_op,
   input  logic [31:0]   a,
   input  logic [31:0]   b,
   output logic [31:0]   res_hi,
   output logic [31:0]   res_lo,
   output logic          div_by_zero
);

   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] a_s;
   logic signed [31:0] b_safe_s;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic        [31:0] b_safe;
   logic               div_ovf;

   always_comb begin
      // Sign-extended 64-bit product keeps the full signed result.
      a_sx   = {{32{a[31]}}, a};
      b_sx   = {{32{b[31]}}, b};
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, a} * {32'd0, b};

      // A zero divisor is replaced so the divider never sees it; the
      // result is discarded at commit anyway.
      b_safe   = (b == 32'd0) ? 32'd1 : b;
      a_s      = a;
      b_safe_s = b_safe;

      // -2^31 / -1 does not fit; MIPS yields quotient -2^31, remainder 0.
      div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (div_ovf) begin
         quot_s = a_s;
         rem_s  = '0;
      end else begin
         quot_s = a_s / b_safe_s;
         rem_s  = a_s % b_safe_s;
      end

      res_hi      = '0;
      res_lo      = '0;
      div_by_zero = is_div_op(md_op) && (b == 32'd0);

      case (md_op)
         MD_MULT:  {res_hi, res_lo} = prod_s;
         MD_MULTU: {res_hi, res_lo} = prod_u;
         MD_DIV: begin
            res_hi = rem_s;
            res_lo = quot_s;
         end
         MD_DIVU: begin
            res_hi = a % b_safe;
            res_lo = a / b_safe;
         end
         default: begin
            res_hi = '0;
            res_lo = '0;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the MIPS datapath.
// The result is computed in the start cycle and held as a pending value;
// a counter models the multi-cycle latency, and HI/LO commit on the last
// busy edge. MTHI/MTLO write HI/LO directly while idle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mult_div_unit_if (start/md_op/operands in,
//                busy/hi/lo out)
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic                clk,
   input  logic                reset,
   mult_div_unit_if.slave      bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   state_t              state;
   logic [CNT_W-1:0]    counter;
   logic [31:0]         pending_hi;
   logic [31:0]         pending_lo;
   logic                pending_dz;
   logic [31:0]         hi;
   logic [31:0]         lo;

   logic [31:0]         res_hi;
   logic [31:0]         res_lo;
   logic                div_by_zero;

   mdu_arith u_arith (
      .md_op       (bus.md_op),
      .a           (bus.rs_val),
      .b           (bus.rt_val),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .div_by_zero (div_by_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         counter    <= '0;
         pending_hi <= '0;
         pending_lo <= '0;
         pending_dz <= 1'b0;
         hi         <= '0;
         lo         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (is_long_op(bus.md_op)) begin
                     state      <= ST_RUN;
                     counter    <= is_div_op(bus.md_op) ? CNT_W'(DIV_CYCLES)
                                                        : CNT_W'(MULT_CYCLES);
                     pending_hi <= res_hi;
                     pending_lo <= res_lo;
                     pending_dz <= div_by_zero;
                  end else if (bus.md_op == MD_MTHI) begin
                     hi <= bus.rs_val;
                  end else if (bus.md_op == MD_MTLO) begin
                     lo <= bus.rs_val;
                  end
               end
            end
            ST_RUN: begin
               // Any start while running is dropped; the hazard unit stalls it.
               if (counter == CNT_W'(1)) begin
                  state   <= ST_IDLE;
                  counter <= '0;
                  if (!pending_dz) begin
                     hi <= pending_hi;
                     lo <= pending_lo;
                  end
               end else begin
                  counter <= counter - CNT_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               counter <= '0;
            end
         endcase
      end
   end

   assign bus.busy = (state == ST_RUN);
   assign bus.hi   = hi;
   assign bus.lo   = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a table of operations with
// hand-computed busy lengths and HI/LO results, followed by sequences
// for start-during-run, reset mid-run, reset/start priority and
// back-to-back issue.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mult_div_unit_if bus();

   mult_div_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      md_op_t      op;
      logic [31:0] a;
      logic [31:0] b;
      int          exp_busy;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge: presents a one-cycle request, returns at the
   // negedge of the following cycle.
   task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
      bus.start  = 1'b1;
      bus.md_op  = op;
      bus.rs_val = a;
      bus.rt_val = b;
      @(negedge clk);
      bus.start  = 1'b0;
   endtask

   // Issues an operation and counts busy cycles; returns in the first
   // cycle where busy is low again.
   task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      issue(op, a, b);
      n = 0;
      while (bus.busy && n < 50) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      logic bad;

      vecs[0]  = '{MD_MULT,  32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE};
      vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{MD_DIVU,  32'd7,         32'd2,         10, 32'h0000_0001, 32'h0000_0003};
      vecs[4]  = '{MD_MTHI,  32'h1234_5678, 32'd0,         0,  32'h1234_5678, 32'h0000_0003};
      vecs[5]  = '{MD_MTLO,  32'h9ABC_DEF0, 32'd0,         0,  32'h1234_5678, 32'h9ABC_DEF0};
      vecs[6]  = '{MD_DIV,   32'd5,         32'd0,         10, 32'h1234_5678, 32'h9ABC_DEF0};
      vecs[7]  = '{MD_DIVU,  32'd5,         32'd0,         10, 32'h1234_5678, 32'h9ABC_DEF0};
      vecs[8]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
      vecs[9]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
      vecs[10] = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h0000_0001};
      vecs[11] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[12] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd10,        10, 32'h0000_0005, 32'h1999_9999};
      vecs[13] = '{MD_MTHI,  32'hDEAD_BEEF, 32'd0,         0,  32'hDEAD_BEEF, 32'h1999_9999};
      vecs[14] = '{MD_NONE,  32'h1111_1111, 32'd1,         0,  32'hDEAD_BEEF, 32'h1999_9999};
      vecs[15] = '{MD_RSVD,  32'h2222_2222, 32'd1,         0,  32'hDEAD_BEEF, 32'h1999_9999};
      vecs[16] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};

      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.md_op  = MD_NONE;
      bus.rs_val = '0;
      bus.rt_val = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset hi", bus.hi, 32'd0);
      check("reset lo", bus.lo, 32'd0);

      for (int i = 0; i < 17; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
         check($sformatf("vec%0d busy cycles", i), 32'(n), 32'(vecs[i].exp_busy));
         check($sformatf("vec%0d hi", i), bus.hi, vecs[i].exp_hi);
         check($sformatf("vec%0d lo", i), bus.lo, vecs[i].exp_lo);
      end

      // MTLO and a second start during a MULT run are both dropped.
      issue(MD_MULT, 32'd6, 32'd7);
      n = 0;
      while (bus.busy && n < 50) begin
         n++;
         if (n == 2) begin
            bus.start = 1'b1; bus.md_op = MD_MTLO; bus.rs_val = 32'd1;
         end else if (n == 3) begin
            bus.start = 1'b1; bus.md_op = MD_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("run-ignore busy cycles", 32'(n), 32'd5);
      check("run-ignore hi", bus.hi, 32'd0);
      check("run-ignore lo", bus.lo, 32'd42);
      @(negedge clk);
      check("run-ignore no restart", 32'(bus.busy), 32'd0);

      // Reset in the third busy cycle of a DIV discards the pending result.
      run_op(MD_MTHI, 32'h0000_0055, 32'd0, n);
      issue(MD_DIV, 32'd100, 32'd7);
      check("div started", 32'(bus.busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid-run reset busy", 32'(bus.busy), 32'd0);
      check("mid-run reset hi", bus.hi, 32'd0);
      check("mid-run reset lo", bus.lo, 32'd0);
      bad = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (bus.busy || bus.hi != 32'd0 || bus.lo != 32'd0) bad = 1'b1;
      end
      check("post-reset quiet", 32'(bad), 32'd0);

      // Reset wins over a start on the same edge.
      reset = 1'b1;
      bus.start = 1'b1; bus.md_op = MD_MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
      @(negedge clk);
      reset = 1'b0;
      bus.start = 1'b0;
      check("reset-priority busy", 32'(bus.busy), 32'd0);
      repeat (6) @(negedge clk);
      check("reset-priority lo", bus.lo, 32'd0);

      // Back-to-back: DIVU issued in the first idle cycle after MULT.
      run_op(MD_MULT, 32'd3, 32'd4, n);
      check("b2b mult busy cycles", 32'(n), 32'd5);
      check("b2b mult hi", bus.hi, 32'd0);
      check("b2b mult lo", bus.lo, 32'd12);
      run_op(MD_DIVU, 32'd100, 32'd7, n);
      check("b2b divu busy cycles", 32'(n), 32'd10);
      check("b2b divu hi", bus.hi, 32'd2);
      check("b2b divu lo", bus.lo, 32'd14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
